// File: rtl/qpolicy_reader.sv
// Greedy-policy extractor: walks the Q table state by state, picks the argmax
// action per state and streams {state, action, qmax} out on a valid/ready port.
module qpolicy_reader #(
   parameter int STATE_BITS  = 6,
   parameter int ACTION_BITS = 2,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              mem_rd_en,
   output logic [STATE_BITS+ACTION_BITS-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0]             mem_rd_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [STATE_BITS-1:0]             out_state,
   output logic [ACTION_BITS-1:0]            out_action,
   output logic [DATA_WIDTH-1:0]             out_qmax,
   output logic                              out_last
);

   localparam int                     AW    = STATE_BITS + ACTION_BITS;
   localparam logic [STATE_BITS-1:0]  S_MAX = '1;
   localparam logic [ACTION_BITS-1:0] A_MAX = '1;

   typedef enum logic [2:0] {IDLE, READ, LAST, OUT, DONE} state_t;

   state_t                 state, state_nxt;
   logic [STATE_BITS-1:0]  s;
   logic [ACTION_BITS-1:0] a;
   logic [AW-1:0]          addr_q;
   logic                   rd_vld;
   logic [ACTION_BITS-1:0] rd_act;
   logic [DATA_WIDTH-1:0]  best;
   logic [ACTION_BITS-1:0] best_act;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_rd_en  = 1'b0;
      mem_addr   = addr_q;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_state  = s;
      out_action = best_act;
      out_qmax   = best;
      case (state)
         IDLE: if (start) state_nxt = READ;
         READ: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = {s, a};
            if (a == A_MAX) state_nxt = LAST;
         end
         LAST: begin
            busy      = 1'b1;
            state_nxt = OUT;
         end
         OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = (s == S_MAX);
            if (out_ready) state_nxt = (s == S_MAX) ? DONE : READ;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read data lands one cycle after the strobe, so the action index is
   // delayed alongside it for the compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s        <= '0;
         a        <= '0;
         addr_q   <= '0;
         rd_vld   <= 1'b0;
         rd_act   <= '0;
         best     <= '0;
         best_act <= '0;
      end else begin
         rd_vld <= mem_rd_en;
         rd_act <= a;
         case (state)
            IDLE: if (start) begin
               s <= '0;
               a <= '0;
            end
            READ: begin
               addr_q <= {s, a};
               a      <= a + 1'b1;
            end
            OUT: if (out_ready && s != S_MAX) s <= s + 1'b1;
            default: ;
         endcase
         if ((state == IDLE && start) || (state == OUT && out_ready)) begin
            best     <= '0;
            best_act <= '0;
         end else if (rd_vld && (rd_act == '0 || mem_rd_data > best)) begin
            // strict compare keeps the lowest action on ties
            best     <= mem_rd_data;
            best_act <= rd_act;
         end
      end
   end

endmodule
